// File: rtl/byte_word_assembler.sv
// Byte-serial to word assembler feeding the divisible-by-five detector.
// Little-endian assembly with frame realignment, backpressure and sticky error flags.
module byte_word_assembler #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    input  logic                 frame_start,
    output logic [BIT_WIDTH-1:0] word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 overflow,
    output logic                 frame_error,
    input  logic                 err_clear
);

    localparam int NBYTES = BIT_WIDTH / 8;
    localparam int CNT_W  = (NBYTES > 2) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [BIT_WIDTH-1:0] word_q;
    logic                 overflow_q;
    logic                 frame_error_q;

    logic accept;
    logic ovf_set;
    logic ferr_set;

    always_comb begin
        byte_ready = (state == FILL) ? 1'b1 : word_ready;
        accept     = byte_valid && byte_ready;
        ovf_set    = byte_valid && !byte_ready;
        // Only a partial word in FILL counts as a misaligned frame start.
        ferr_set   = (state == FILL) && frame_start && (count != '0);
    end

    assign word_out    = word_q;
    assign word_valid  = (state == FULL);
    assign overflow    = overflow_q;
    assign frame_error = frame_error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FILL;
            count         <= '0;
            word_q        <= '0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            overflow_q    <= ovf_set  | (overflow_q    & ~err_clear);
            frame_error_q <= ferr_set | (frame_error_q & ~err_clear);

            case (state)
                FILL: begin
                    if (accept) begin
                        if (frame_start || count == '0) begin
                            word_q <= {{(BIT_WIDTH-8){1'b0}}, byte_in};
                            count  <= CNT_W'(1);
                        end else begin
                            word_q[8*count +: 8] <= byte_in;
                            if (count == LAST_IDX) begin
                                state <= FULL;
                                count <= '0;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end else if (frame_start) begin
                        count <= '0;
                    end
                end
                FULL: begin
                    // A byte arriving with the handshake opens the next word.
                    if (word_ready) begin
                        state <= FILL;
                        if (byte_valid) begin
                            word_q <= {{(BIT_WIDTH-8){1'b0}}, byte_in};
                            count  <= CNT_W'(1);
                        end else begin
                            count  <= '0;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_word_assembler.sv
// Self-checking bench for byte_word_assembler: directed vector table,
// a backpressure sequence and randomized traffic against a queue-based model.
module tb_byte_word_assembler;

    localparam int BW = 32;
    localparam int NB = BW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          frame_start;
    logic [BW-1:0] word_out;
    logic          word_valid;
    logic          word_ready;
    logic          overflow;
    logic          frame_error;
    logic          err_clear;

    always #5 clk = ~clk;

    byte_word_assembler #(.BIT_WIDTH(BW)) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .frame_start (frame_start),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overflow    (overflow),
        .frame_error (frame_error),
        .err_clear   (err_clear)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: accepted bytes of the current word kept as a queue.
    logic          m_full;
    logic [7:0]    q[$];
    logic [BW-1:0] m_word;
    logic          m_ovf;
    logic          m_ferr;
    logic          last_brdy;

    typedef struct {
        logic          r;
        logic          bv;
        logic [7:0]    b;
        logic          fs;
        logic          wr;
        logic          ec;
        logic          e_brdy;
        logic          e_wv;
        logic [BW-1:0] e_word;
        logic          e_ovf;
        logic          e_ferr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] assemble();
        logic [BW-1:0] w = '0;
        for (int k = 0; k < q.size(); k++) w[8*k +: 8] = q[k];
        return w;
    endfunction

    task automatic apply(input logic r, input logic bv, input logic [7:0] b,
                         input logic fs, input logic wr, input logic ec);
        logic rdy, acc, ovf_set, ferr_set;
        rst = r; byte_valid = bv; byte_in = b; frame_start = fs;
        word_ready = wr; err_clear = ec;
        #1;
        rdy = !m_full || wr;
        last_brdy = byte_ready;
        chk("byte_ready", {63'd0, byte_ready}, {63'd0, rdy});
        @(posedge clk);
        if (r) begin
            m_full = 1'b0; q.delete(); m_word = '0; m_ovf = 1'b0; m_ferr = 1'b0;
        end else begin
            acc      = bv && rdy;
            ovf_set  = bv && !rdy;
            ferr_set = !m_full && fs && (q.size() > 0);
            if (m_full) begin
                if (wr) begin
                    m_full = 1'b0;
                    q.delete();
                    if (acc) q.push_back(b);
                end
            end else begin
                if (fs) q.delete();
                if (acc) q.push_back(b);
                if (q.size() == NB) m_full = 1'b1;
            end
            if (acc) m_word = assemble();
            m_ovf  = ovf_set  | (m_ovf  & ~ec);
            m_ferr = ferr_set | (m_ferr & ~ec);
        end
        #1;
        chk("word_valid",  {63'd0, word_valid},  {63'd0, m_full});
        chk("word_out",    {32'd0, word_out},    {32'd0, m_word});
        chk("overflow",    {63'd0, overflow},    {63'd0, m_ovf});
        chk("frame_error", {63'd0, frame_error}, {63'd0, m_ferr});
    endtask

    task automatic addv(input logic r, input logic bv, input logic [7:0] b, input logic fs,
                        input logic wr, input logic ec, input logic e_brdy, input logic e_wv,
                        input logic [BW-1:0] e_word, input logic e_ovf, input logic e_ferr);
        vec_t v;
        v.r = r; v.bv = bv; v.b = b; v.fs = fs; v.wr = wr; v.ec = ec;
        v.e_brdy = e_brdy; v.e_wv = e_wv; v.e_word = e_word; v.e_ovf = e_ovf; v.e_ferr = e_ferr;
        vecs.push_back(v);
    endtask

    initial begin
        m_full = 1'b0; m_word = '0; m_ovf = 1'b0; m_ferr = 1'b0;
        rst = 1'b1; byte_valid = 1'b0; byte_in = '0; frame_start = 1'b0;
        word_ready = 1'b0; err_clear = 1'b0;

        // Reset state
        @(posedge clk); #1;
        apply(1, 0, 8'h00, 0, 0, 0);
        chk("rst_word_out", {32'd0, word_out}, 64'd0);
        chk("rst_word_valid", {63'd0, word_valid}, 64'd0);
        chk("rst_flags", {62'd0, overflow, frame_error}, 64'd0);
        chk("rst_byte_ready", {63'd0, byte_ready}, 64'd1);

        //    r  bv b      fs wr ec | brdy wv word          ovf ferr
        addv(0, 1, 8'h11, 0, 1, 0,   1,   0, 32'h00000011, 0,  0);
        addv(0, 1, 8'h22, 0, 1, 0,   1,   0, 32'h00002211, 0,  0);
        addv(0, 1, 8'h33, 0, 1, 0,   1,   0, 32'h00332211, 0,  0);
        addv(0, 1, 8'h44, 0, 1, 0,   1,   1, 32'h44332211, 0,  0);
        addv(0, 0, 8'h00, 0, 1, 0,   1,   0, 32'h44332211, 0,  0);
        addv(0, 1, 8'h01, 0, 1, 0,   1,   0, 32'h00000001, 0,  0);
        addv(0, 1, 8'h02, 0, 1, 0,   1,   0, 32'h00000201, 0,  0);
        addv(0, 1, 8'h10, 1, 1, 0,   1,   0, 32'h00000010, 0,  1);
        addv(0, 1, 8'h20, 0, 1, 0,   1,   0, 32'h00002010, 0,  1);
        addv(0, 1, 8'h30, 0, 1, 0,   1,   0, 32'h00302010, 0,  1);
        addv(0, 1, 8'h40, 0, 0, 0,   1,   1, 32'h40302010, 0,  1);
        addv(0, 0, 8'h00, 0, 0, 1,   0,   1, 32'h40302010, 0,  0);
        addv(0, 0, 8'h00, 1, 0, 0,   0,   1, 32'h40302010, 0,  0);
        addv(0, 1, 8'hAA, 0, 0, 1,   0,   1, 32'h40302010, 1,  0);
        addv(0, 0, 8'h00, 0, 0, 1,   0,   1, 32'h40302010, 0,  0);
        addv(0, 1, 8'h55, 0, 1, 0,   1,   0, 32'h00000055, 0,  0);
        addv(0, 1, 8'h66, 0, 1, 0,   1,   0, 32'h00006655, 0,  0);
        addv(1, 1, 8'h77, 0, 1, 0,   1,   0, 32'h00000000, 0,  0);
        addv(0, 1, 8'hDE, 0, 1, 0,   1,   0, 32'h000000DE, 0,  0);
        addv(0, 1, 8'hAD, 0, 1, 0,   1,   0, 32'h0000ADDE, 0,  0);
        addv(0, 1, 8'hBE, 0, 1, 0,   1,   0, 32'h00BEADDE, 0,  0);
        addv(0, 1, 8'hEF, 0, 0, 0,   1,   1, 32'hEFBEADDE, 0,  0);
        addv(0, 0, 8'h00, 0, 1, 0,   1,   0, 32'hEFBEADDE, 0,  0);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].bv, vecs[i].b, vecs[i].fs, vecs[i].wr, vecs[i].ec);
            chk($sformatf("vec%0d_brdy", i), {63'd0, last_brdy}, {63'd0, vecs[i].e_brdy});
            chk($sformatf("vec%0d_wv", i), {63'd0, word_valid}, {63'd0, vecs[i].e_wv});
            chk($sformatf("vec%0d_word", i), {32'd0, word_out}, {32'd0, vecs[i].e_word});
            chk($sformatf("vec%0d_ovf", i), {63'd0, overflow}, {63'd0, vecs[i].e_ovf});
            chk($sformatf("vec%0d_ferr", i), {63'd0, frame_error}, {63'd0, vecs[i].e_ferr});
        end

        // Backpressure: word held for 5 cycles while 0xAA is offered and dropped
        apply(0, 1, 8'hA1, 0, 0, 1);
        apply(0, 1, 8'hB2, 0, 0, 0);
        apply(0, 1, 8'hC3, 0, 0, 0);
        apply(0, 1, 8'hD4, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 8'hAA, 0, 0, 0);
            chk("bp_brdy", {63'd0, last_brdy}, 64'd0);
            chk("bp_word", {32'd0, word_out}, {32'd0, 32'hD4C3B2A1});
            chk("bp_ovf", {63'd0, overflow}, 64'd1);
        end
        apply(0, 1, 8'h55, 0, 1, 0);
        chk("bp_hs_wv", {63'd0, word_valid}, 64'd0);
        chk("bp_hs_byte0", {32'd0, word_out}, {32'd0, 32'h00000055});
        apply(0, 1, 8'h66, 0, 1, 0);
        apply(0, 1, 8'h77, 0, 1, 0);
        apply(0, 1, 8'h88, 0, 1, 0);
        chk("bp_next_word", {32'd0, word_out}, {32'd0, 32'h88776655});
        chk("bp_next_wv", {63'd0, word_valid}, 64'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            apply(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 7),
                  8'($urandom),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_word_assembler.md
Name: byte_word_assembler

Overview:
- Upstream feeder for the divisible-by-five detector.
- Collects a byte-serial operand from the 8-bit input pins and assembles a BIT_WIDTH-bit word.
- Presents the completed word to the detector through a valid/ready handshake.
- Handles frame alignment, backpressure and sticky error flags so the detector only ever receives whole, correctly ordered operands.

Parameters:
- BIT_WIDTH, 32, operand width in bits; must be a multiple of 8 and at least 16.
- NBYTES, BIT_WIDTH/8, derived byte count per word (localparam, not overridable).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- byte_in  input  8  serial operand byte
- byte_valid  input  1  byte_in carries a byte this cycle
- byte_ready  output  1  block accepts byte_in this cycle
- frame_start  input  1  marks byte_in as byte 0 of a new word; realigns the assembler
- word_out  output  BIT_WIDTH  assembled operand to the detector
- word_valid  output  1  word_out holds a complete word
- word_ready  input  1  detector consumes word_out this cycle
- overflow  output  1  sticky: a byte was offered while byte_ready=0 and was dropped
- frame_error  output  1  sticky: frame_start arrived with a partial word pending
- err_clear  input  1  clears both sticky flags

Behaviour:
- Reset, checked on the clk edge:
  - state=FILL, byte count=0.
  - word_out=0, word_valid=0, overflow=0, frame_error=0.
  - Reset mid-word discards the partial word with no error.
- Byte order is little-endian: the first byte accepted is word_out[7:0] and byte k lands in word_out[8k+7:8k].
- A byte is accepted when byte_valid && byte_ready. When byte 0 is accepted, all higher bytes of the assembly register clear to 0.
- byte_ready is combinational: 1 in FILL; in FULL, byte_ready = word_ready.
- State FILL (word_valid=0):
  - Each accepted byte increments the count.
  - Accepting byte NBYTES-1 moves to FULL.
  - Latency: last byte accepted on edge N gives word_valid=1 from edge N.
- State FULL (word_valid=1):
  - word_out is held stable until handshake.
  - Handshake (word_valid && word_ready) with no byte accepted: go to FILL, count=0, word_valid=0.
  - Handshake with a byte accepted in the same cycle: that byte becomes byte 0 of the next word, count=1, state FILL. The frame_start value is irrelevant here because the count is already 0.
- frame_start:
  - Applies only in FILL or on an accepted byte.
  - In FILL with count>0: drop the partial word, set frame_error.
  - The count becomes 0, then becomes 1 if a byte is accepted in the same cycle, taken as byte 0.
  - frame_start with count=0 has no error.
  - frame_start in FULL without an accepted byte is ignored; the word is not corrupted and no error is raised.
- overflow is set on any cycle with byte_valid && !byte_ready. The byte is discarded and the count is unchanged.
- err_clear clears both flags. If err_clear coincides with a new error event, the set wins.
- The word register is written only on accepted bytes; no other path changes word_out.
- No combinational path from byte_in to word_out. Only byte_ready depends combinationally on word_ready.

Test Plan:
- Back-to-back fill: bytes 0x11,0x22,0x33,0x44 on consecutive cycles with word_ready=1 → word_valid=1 on the cycle after 0x44, word_out=0x44332211, handshake completes, and word_valid=0 on the next cycle.
- Backpressure: a word completes with word_ready=0 for 5 cycles while byte_valid=1 with 0xAA → byte_ready=0, word_out stays stable, overflow=1. Then word_ready=1 with byte 0x55 in the same cycle → handshake completes, next word's byte 0 is 0x55, count=1.
- Realignment: bytes 0x01,0x02, then 0x10 with frame_start=1, then 0x20,0x30,0x40 → frame_error=1, word_out=0x40302010.
- frame_start in FULL without an accepted byte → word_out unchanged, frame_error stays 0.
- Error clear priority: err_clear=1 in the same cycle as an overflow event → overflow remains 1. err_clear alone on the next cycle → both flags read 0.
- Reset mid-operation: rst asserted after 2 of 4 bytes, then released and 4 new bytes 0xDE,0xAD,0xBE,0xEF sent → word_out=0xEFBEADDE, no error flags. During reset, all outputs are 0 and byte_ready=1.
